// File: rtl/seq_shifter.sv
// Iterative 32-bit shift/rotate unit: shifts STEP bits per cycle under a
// start/busy/done handshake, so latency scales with the shift amount.
module seq_shifter #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] data_in,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  count;
  logic [4:0]  k;
  logic [4:0]  count_next;
  logic [31:0] stepped;
  logic        op_legal;

  assign op_legal = (op <= OP_ROL);

  // One step of the captured operation; the last step may be shorter than STEP.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    stepped    = result;
    k          = (count < STEP_AMT) ? count : STEP_AMT;
    count_next = count - k;
    case (op_q)
      OP_SLL:  stepped = result << k;
      OP_SRL:  stepped = result >> k;
      OP_SRA:  stepped = $signed(result) >>> k;
      OP_ROR:  stepped = (result >> k) | (result << (6'd32 - {1'b0, k}));
      OP_ROL:  stepped = (result << k) | (result >> (6'd32 - {1'b0, k}));
      default: stepped = result;
    endcase
  end

  // A zero-bit rotate shifts the wrap term by 32, which yields 0 and keeps result intact.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      op_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            result <= data_in;
            count  <= shamt;
            busy   <= 1'b1;
            if (shamt != 5'd0 && op_legal) begin
              state <= SHIFT;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result <= stepped;
          count  <= count_next;
          if (count_next == 5'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances share inputs and are
// checked against a whole-shift reference model and cycle-exact latency.
module tb_seq_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] r1, r4;
  logic        b1, b4, d1, d4;

  int total = 0;
  int bad   = 0;

  seq_shifter #(.STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .result(r1), .busy(b1), .done(d1)
  );

  seq_shifter #(.STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .result(r4), .busy(b4), .done(d4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full shift computed in one go from the operation's definition.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [4:0] sh,
                                        input logic [31:0] d);
    logic [63:0] dd;
    dd = {d, d};
    case (o)
      3'd0:    return d << sh;
      3'd1:    return d >> sh;
      3'd2:    return 32'($signed(d) >>> sh);
      3'd3:    begin dd = dd >> sh; return dd[31:0];  end
      3'd4:    begin dd = dd << sh; return dd[63:32]; end
      default: return d;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [4:0] sh, input int s);
    if (o > 3'd4 || sh == 5'd0) return 0;
    return (int'(sh) + s - 1) / s;
  endfunction

  // Issues one operation and checks busy/done every cycle plus the held result.
  task automatic run_op(input logic [2:0] o, input logic [4:0] sh, input logic [31:0] d,
                        input logic [31:0] exp, input string name);
    int m[2];
    int last;
    m[0] = lat(o, sh, 1);
    m[1] = lat(o, sh, 4);
    last = ((m[0] > m[1]) ? m[0] : m[1]) + 2;
    @(negedge clk);
    op = o; shamt = sh; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); shamt = 5'($urandom); data_in = $urandom;
    for (int cyc = 1; cyc <= last; cyc++) begin
      for (int u = 0; u < 2; u++) begin
        logic [31:0] rr;
        logic        bb, dn;
        rr = (u == 0) ? r1 : r4;
        bb = (u == 0) ? b1 : b4;
        dn = (u == 0) ? d1 : d4;
        check($sformatf("%s s%0d c%0d busy", name, (u == 0) ? 1 : 4, cyc), {31'd0, bb},
              {31'd0, (cyc <= m[u] + 1)});
        check($sformatf("%s s%0d c%0d done", name, (u == 0) ? 1 : 4, cyc), {31'd0, dn},
              {31'd0, (cyc == m[u] + 1)});
        if (cyc >= m[u] + 1)
          check($sformatf("%s s%0d c%0d result", name, (u == 0) ? 1 : 4, cyc), rr, exp);
      end
      if (cyc < last) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] a_val, b_val, rd;
    logic [2:0]  ro;
    logic [4:0]  rs;
    int nd1, nd4;

    reset = 1'b0; start = 1'b0; op = '0; shamt = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst r1", r1, 32'h0);
    check("rst b1", {31'd0, b1}, 32'd0);
    check("rst d1", {31'd0, d1}, 32'd0);
    check("rst r4", r4, 32'h0);
    check("rst b4", {31'd0, b4}, 32'd0);
    check("rst d4", {31'd0, d4}, 32'd0);
    reset = 1'b1;

    run_op(3'd0, 5'd31, 32'h0000_0001, 32'h8000_0000, "sll31");
    run_op(3'd2, 5'd4,  32'h8000_0000, 32'hF800_0000, "sra4");
    run_op(3'd1, 5'd4,  32'h8000_0000, 32'h0800_0000, "srl4");
    run_op(3'd3, 5'd8,  32'h1234_5678, 32'h7812_3456, "ror8");
    run_op(3'd4, 5'd8,  32'h1234_5678, 32'h3456_7812, "rol8");
    run_op(3'd3, 5'd0,  32'h1234_5678, 32'h1234_5678, "ror0");
    run_op(3'd1, 5'd5,  32'hFFFF_FFFF, 32'h07FF_FFFF, "srl5");
    run_op(3'd7, 5'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "illegal");

    // start held high: every operation takes the operand present in its IDLE cycle.
    a_val = 32'h0000_00F1;
    b_val = 32'h0101_0003;
    nd1 = 0; nd4 = 0;
    @(negedge clk);
    op = 3'd0; shamt = 5'd3; data_in = a_val; start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == 1) data_in = b_val;
      if (d1) begin
        nd1++;
        check($sformatf("held s1 res#%0d", nd1), r1, (nd1 == 1) ? a_val << 3 : b_val << 3);
        if (nd1 <= 2) check($sformatf("held s1 cyc#%0d", nd1), cyc, (nd1 == 1) ? 4 : 9);
      end
      if (d4) begin
        nd4++;
        check($sformatf("held s4 res#%0d", nd4), r4, (nd4 == 1) ? a_val << 3 : b_val << 3);
      end
      @(negedge clk);
    end
    check("held s1 count", nd1, 2);
    check("held s4 count", nd4, 4);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Reset in cycle 3 of an SLL by 20 aborts with no done.
    op = 3'd0; shamt = 5'd20; data_in = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort r1", r1, 32'h0);
    check("abort b1", {31'd0, b1}, 32'd0);
    check("abort d1", {31'd0, d1}, 32'd0);
    check("abort r4", r4, 32'h0);
    check("abort b4", {31'd0, b4}, 32'd0);
    check("abort d4", {31'd0, d4}, 32'd0);
    reset = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      check($sformatf("post-abort c%0d d1", cyc), {31'd0, d1}, 32'd0);
      check($sformatf("post-abort c%0d d4", cyc), {31'd0, d4}, 32'd0);
    end
    run_op(3'd0, 5'd20, 32'h0000_0001, 32'h0010_0000, "fresh");

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rs = 5'($urandom);
      rd = $urandom;
      run_op(ro, rs, rd, model(ro, rs, rd), $sformatf("rnd%0d op%0d sh%0d", i, ro, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
